// File: rtl/key_matrix_encoder.sv
// Scanned 8x8 key matrix encoder: strobes columns, debounces per frame, emits one address per press.
// Build option KEY_MATRIX_MULTI_KEY_DETECT_EN rejects frames holding more than one active key.
module key_matrix_encoder #(
  parameter int unsigned SCAN_DIV = 16,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] row_in,
  output logic [7:0] col_drv,
  output logic [5:0] add,
  output logic       valid,
  input  logic       ready,
  output logic       overrun,
  output logic       multi
);

  localparam int unsigned DwellW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DwellW-1:0] DwellLast = DwellW'(SCAN_DIV - 1);
  localparam logic [3:0] DebMax = 4'(DEBOUNCE);
  // Key code {none, col[2:0], row[2:0]}; bit 6 set encodes NONE.
  localparam logic [6:0] KeyNone = 7'h40;

  typedef enum logic [0:0] {StReleased, StPressed} state_e;

  logic [7:0]        sync_q, row_s_q;
  logic [DwellW-1:0] dwell_q, dwell_d;
  logic [2:0]        col_q, col_d;
  logic [6:0]        frame_q, frame_d, col_hit, frame_cand, cand;
  logic [6:0]        prev_q, prev_d, accepted_q, accepted_d;
  logic [3:0]        stable_q, stable_d;
  state_e            state_q, state_d;
  logic              key_change, key_event;
  logic              valid_q, valid_d, overrun_q, overrun_d;
  logic [5:0]        add_q, add_d;
  logic              sample, frame_end;

  assign sample    = (dwell_q == DwellLast);
  assign frame_end = sample && (col_q == 3'd7);
  assign col_drv   = 8'd1 << col_q;
  assign add       = add_q;
  assign valid     = valid_q;
  assign overrun   = overrun_q;

  always_comb begin
    dwell_d = dwell_q + DwellW'(1);
    col_d   = col_q;
    if (sample) begin
      dwell_d = '0;
      col_d   = col_q + 3'd1;
    end
  end

  // Lowest active row in the column being sampled.
  always_comb begin
    col_hit = KeyNone;
    for (int r = 7; r >= 0; r--) begin
      if (row_s_q[r]) col_hit = {1'b0, col_q, 3'(r)};
    end
  end

  assign frame_cand = frame_q[6] ? col_hit : frame_q;

  always_comb begin
    frame_d = frame_q;
    if (sample) frame_d = frame_end ? KeyNone : frame_cand;
  end

`ifdef KEY_MATRIX_MULTI_KEY_DETECT_EN
  logic [1:0] nbits_q, nbits_d;
  logic [4:0] nbits_sum;
  logic       many, multi_q;

  // Active-bit count saturates at 2; only "more than one" matters.
  assign nbits_sum = 5'(nbits_q) + 5'($countones(row_s_q));
  assign many      = (nbits_sum >= 5'd2);
  assign cand      = many ? KeyNone : frame_cand;
  assign multi     = multi_q;

  always_comb begin
    nbits_d = nbits_q;
    if (sample) nbits_d = frame_end ? 2'd0 : (many ? 2'd2 : nbits_sum[1:0]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nbits_q <= 2'd0;
      multi_q <= 1'b0;
    end else begin
      nbits_q <= nbits_d;
      multi_q <= frame_end && many;
    end
  end
`else
  assign cand  = frame_cand;
  assign multi = 1'b0;
`endif

  always_comb begin
    prev_d     = prev_q;
    stable_d   = stable_q;
    accepted_d = accepted_q;
    if (frame_end) begin
      prev_d = cand;
      if (cand == prev_q) stable_d = (stable_q >= DebMax) ? DebMax : stable_q + 4'd1;
      else                stable_d = 4'd1;
      if (stable_d == DebMax && cand != accepted_q) accepted_d = cand;
    end
  end

  assign key_change = (accepted_d != accepted_q);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StReleased: if (key_change && !accepted_d[6]) state_d = StPressed;
      StPressed:  if (key_change && accepted_d[6])  state_d = StReleased;
      default:    state_d = StReleased;
    endcase
  end

  always_comb begin
    key_event = 1'b0;
    unique case (state_q)
      StReleased, StPressed: key_event = key_change && !accepted_d[6];
      default:               key_event = 1'b0;
    endcase
  end

  // A new event wins over a completing handshake in the same cycle.
  always_comb begin
    valid_d   = valid_q;
    add_d     = add_q;
    overrun_d = 1'b0;
    if (key_event) begin
      if (!valid_q || ready) begin
        valid_d = 1'b1;
        add_d   = accepted_d[5:0];
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= 8'd0;
      row_s_q    <= 8'd0;
      dwell_q    <= '0;
      col_q      <= 3'd0;
      frame_q    <= KeyNone;
      prev_q     <= KeyNone;
      stable_q   <= 4'd0;
      accepted_q <= KeyNone;
      state_q    <= StReleased;
      valid_q    <= 1'b0;
      add_q      <= 6'd0;
      overrun_q  <= 1'b0;
    end else begin
      sync_q     <= row_in;
      row_s_q    <= sync_q;
      dwell_q    <= dwell_d;
      col_q      <= col_d;
      frame_q    <= frame_d;
      prev_q     <= prev_d;
      stable_q   <= stable_d;
      accepted_q <= accepted_d;
      state_q    <= state_d;
      valid_q    <= valid_d;
      add_q      <= add_d;
      overrun_q  <= overrun_d;
    end
  end

endmodule

// File: tb/tb_key_matrix_encoder.sv
// Bench for key_matrix_encoder: frame-level behavioural model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_key_matrix_encoder;

  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned DEBOUNCE = 2;
  localparam int Frame = 8 * SCAN_DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] row_in;
  logic [7:0] col_drv;
  logic [5:0] add;
  logic       valid, ready, overrun, multi;

  logic [7:0] mat [8];

  int n_cmp = 0;
  int n_bad = 0;
  int ovr_seen = 0;
  int multi_seen = 0;

  // Model state: keys are c*8+r, -1 is NONE.
  int   t;
  int   m_prev, m_stable, m_acc;
  logic       exp_valid, exp_ovr, exp_multi;
  logic [5:0] exp_add;
  logic [7:0] exp_col;

  key_matrix_encoder #(
    .SCAN_DIV(SCAN_DIV),
    .DEBOUNCE(DEBOUNCE)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .row_in (row_in),
    .col_drv(col_drv),
    .add    (add),
    .valid  (valid),
    .ready  (ready),
    .overrun(overrun),
    .multi  (multi)
  );

  always #5 clk = ~clk;

  // Physical matrix: the strobed column returns its pressed rows.
  always_comb begin
    row_in = 8'd0;
    for (int c = 0; c < 8; c++) begin
      if (col_drv[c]) row_in = row_in | mat[c];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    t = 0;
    m_prev = -1;
    m_stable = 0;
    m_acc = -1;
    exp_valid = 1'b0;
    exp_add = 6'd0;
    exp_ovr = 1'b0;
    exp_multi = 1'b0;
    exp_col = 8'h01;
  endtask

  task automatic model_step();
    int cand;
    int nbits;
    bit mflag;
    bit evt;
    mflag = 1'b0;
    evt = 1'b0;
    if (t % Frame == Frame - 1) begin
      cand = -1;
      nbits = 0;
      for (int c = 0; c < 8; c++) begin
        for (int r = 0; r < 8; r++) begin
          if (mat[c][r]) begin
            nbits++;
            if (cand < 0) cand = c * 8 + r;
          end
        end
      end
`ifdef KEY_MATRIX_MULTI_KEY_DETECT_EN
      if (nbits >= 2) begin
        cand = -1;
        mflag = 1'b1;
      end
`endif
      if (cand == m_prev) m_stable = (m_stable < DEBOUNCE) ? m_stable + 1 : DEBOUNCE;
      else m_stable = 1;
      m_prev = cand;
      if (m_stable == DEBOUNCE && cand != m_acc) begin
        m_acc = cand;
        evt = (cand >= 0);
      end
    end
    exp_ovr = 1'b0;
    exp_multi = mflag;
    if (evt) begin
      if (!exp_valid || ready) begin
        exp_valid = 1'b1;
        exp_add = 6'(m_acc);
      end else begin
        exp_ovr = 1'b1;
      end
    end else if (exp_valid && ready) begin
      exp_valid = 1'b0;
    end
    t++;
    exp_col = 8'd1 << ((t / SCAN_DIV) % 8);
  endtask

  // Compare process: advance the model at each edge, check at the falling edge.
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (!rst_n) model_reset();
      else model_step();
      @(negedge clk);
      if (!rst_n) model_reset();
      check("col_drv", 32'(col_drv), 32'(exp_col));
      check("valid", 32'(valid), 32'(exp_valid));
      check("add", 32'(add), 32'(exp_add));
      check("overrun", 32'(overrun), 32'(exp_ovr));
      check("multi", 32'(multi), 32'(exp_multi));
      if (overrun) ovr_seen++;
      if (multi) multi_seen++;
    end
  end

  task automatic clear_mat();
    for (int c = 0; c < 8; c++) mat[c] = 8'd0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    ready = 1'b0;
    #1;
    check("rst_col_drv", 32'(col_drv), 32'h01);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_add", 32'(add), 32'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic frames(input int n);
    repeat (n * Frame) @(posedge clk);
    #1;
  endtask

  // Ready high for the first cycle of one frame; keeps frame alignment.
  task automatic pulse_ready();
    ready = 1'b1;
    @(posedge clk);
    #1 ready = 1'b0;
    repeat (Frame - 1) @(posedge clk);
    #1;
  endtask

  int ovr_base, multi_base;

  initial begin
    clear_mat();
    ready = 1'b0;
    #2 rst_n = 1'b0;
    do_reset();

    // Single press at column 2, row 5.
    mat[2] = 8'h20;
    frames(1);
    check("press_early_valid", 32'(valid), 32'h0);
    frames(1);
    check("press_valid", 32'(valid), 32'h1);
    check("press_add", 32'(add), 32'h15);
    frames(2);
    check("press_hold_valid", 32'(valid), 32'h1);
    check("press_hold_add", 32'(add), 32'h15);
    pulse_ready();
    check("press_ack_valid", 32'(valid), 32'h0);
    frames(3);
    check("press_no_repeat", 32'(valid), 32'h0);

    // Key held through a reset is reported again.
    do_reset();
    frames(2);
    check("rst_held_valid", 32'(valid), 32'h1);
    check("rst_held_add", 32'(add), 32'h15);

    // Direct key change then release.
    clear_mat();
    do_reset();
    mat[1] = 8'h01;
    frames(2);
    check("chg1_add", 32'(add), 32'h08);
    pulse_ready();
    mat[1] = 8'h00;
    mat[6] = 8'h80;
    frames(2);
    check("chg2_valid", 32'(valid), 32'h1);
    check("chg2_add", 32'(add), 32'h37);
    pulse_ready();
    mat[6] = 8'h00;
    frames(3);
    check("chg_release", 32'(valid), 32'h0);

    // Bounce on column 0, row 3.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      mat[0] = (i % 2 == 0) ? 8'h08 : 8'h00;
      frames(1);
    end
    check("bounce_valid", 32'(valid), 32'h0);
    mat[0] = 8'h08;
    frames(2);
    check("bounce_stable_valid", 32'(valid), 32'h1);
    check("bounce_stable_add", 32'(add), 32'h03);

    // Overrun: second press while the first is unconsumed.
    clear_mat();
    do_reset();
    ovr_base = ovr_seen;
    mat[2] = 8'h02;
    frames(2);
    check("ovr_first_add", 32'(add), 32'h11);
    mat[2] = 8'h00;
    frames(2);
    mat[4] = 8'h10;
    frames(2);
    repeat (2) @(posedge clk);
    #1;
    check("ovr_valid", 32'(valid), 32'h1);
    check("ovr_add_kept", 32'(add), 32'h11);
    check("ovr_pulses", 32'(ovr_seen - ovr_base), 32'd1);

    // Two keys held together.
    clear_mat();
    do_reset();
    multi_base = multi_seen;
    mat[0] = 8'h02;
    mat[3] = 8'h10;
    frames(3);
    repeat (2) @(posedge clk);
    #1;
`ifdef KEY_MATRIX_MULTI_KEY_DETECT_EN
    check("multi_valid", 32'(valid), 32'h0);
    check("multi_pulses", 32'(multi_seen - multi_base), 32'd3);
`else
    check("multi_off_valid", 32'(valid), 32'h1);
    check("multi_off_add", 32'(add), 32'h01);
    check("multi_off_pulses", 32'(multi_seen - multi_base), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
